// File: rtl/bus_pkg.sv
// Shared bus definitions: default word/burst/address widths and the read-serializer
// state encodings.
package bus_pkg;
  localparam int DATA_LEN_DEF   = 8;
  localparam int BURST_LEN_DEF  = 12;
  localparam int ADDR_WIDTH_DEF = 12;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/bit_serializer.sv
// Shift register plus bit counter: loads a word and shifts it out LSB-first.
// With SLAVE_OUT_PREFETCH_EN it also flags the second-to-last bit for early fetch.
module bit_serializer #(
  parameter int DATA_LEN = 8,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic [DATA_LEN-1:0] data,
  input  logic                shift_en,
  output logic                bit_out,
  output logic                last_bit
`ifdef SLAVE_OUT_PREFETCH_EN
  ,
  output logic                penult_bit
`endif
);
  logic [DATA_LEN-1:0] shreg_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;

  // load wins over shift so a new word can start on the last bit of the previous one
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (load) begin
      shreg_reg   <= data;
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      shreg_reg   <= shreg_reg >> 1;
      bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
    end
  end

  assign bit_out  = shreg_reg[0];
  assign last_bit = (bit_cnt_reg == CNT_W'(DATA_LEN - 1));
`ifdef SLAVE_OUT_PREFETCH_EN
  assign penult_bit = (bit_cnt_reg == CNT_W'(DATA_LEN - 2));
`endif
endmodule

// File: rtl/slave_out_port.sv
// Slave read-data serializer: fetches burst_num+1 words and streams them LSB-first.
// SLAVE_OUT_PREFETCH_EN removes the 2-cycle inter-word gap by prefetching the next word.
module slave_out_port
  import bus_pkg::*;
#(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [BURST_LEN-1:0]  burst_num,
  input  logic                  approval_grant,
  input  logic                  master_ready,
  input  logic [DATA_LEN-1:0]   mem_rdata,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  slave_valid,
  output logic                  tx_data,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [BURST_LEN-1:0]  burst_reg, burst_next;
  logic [BURST_LEN-1:0]  word_cnt_reg, word_cnt_next;
  logic                  ser_load, ser_shift, ser_clear, ser_bit, ser_last, abort;
  logic [DATA_LEN-1:0]   ser_data;
  logic                  last_word;
`ifdef SLAVE_OUT_PREFETCH_EN
  logic                  ser_penult;
  logic                  pf_issued_reg, pf_issued_next;
  logic                  pf_inflight_reg, pf_inflight_next;
  logic [DATA_LEN-1:0]   pf_data_reg, pf_data_next;
`endif

  assign last_word = (word_cnt_reg == burst_reg);

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    burst_next    = burst_reg;
    word_cnt_next = word_cnt_reg;
    ser_load      = 1'b0;
    ser_data      = mem_rdata;
    ser_shift     = 1'b0;
    ser_clear     = 1'b0;
    abort         = 1'b0;
    mem_rd        = 1'b0;
    slave_valid   = 1'b0;
    tx_done       = 1'b0;
`ifdef SLAVE_OUT_PREFETCH_EN
    pf_issued_next   = pf_issued_reg;
    pf_inflight_next = 1'b0;
    pf_data_next     = pf_inflight_reg ? mem_rdata : pf_data_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (read_req && approval_grant) begin
          cur_addr_next = start_addr;
          burst_next    = burst_num;
          word_cnt_next = '0;
          state_next    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!approval_grant) abort = 1'b1;
        else begin
          mem_rd     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!approval_grant) abort = 1'b1;
        else begin
          ser_load      = 1'b1;
          cur_addr_next = cur_addr_reg + ADDR_WIDTH'(1);
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!approval_grant) abort = 1'b1;
        else begin
`ifdef SLAVE_OUT_PREFETCH_EN
          // one early read per word, independent of master stalls
          if (ser_penult && !pf_issued_reg && !last_word) begin
            mem_rd           = 1'b1;
            cur_addr_next    = cur_addr_reg + ADDR_WIDTH'(1);
            pf_issued_next   = 1'b1;
            pf_inflight_next = 1'b1;
          end
`endif
          if (master_ready) begin
            slave_valid = 1'b1;
            ser_shift   = 1'b1;
            if (ser_last) begin
              if (last_word) state_next = ST_DONE;
              else begin
                word_cnt_next = word_cnt_reg + BURST_LEN'(1);
`ifdef SLAVE_OUT_PREFETCH_EN
                ser_load       = 1'b1;
                ser_data       = pf_inflight_reg ? mem_rdata : pf_data_reg;
                pf_issued_next = 1'b0;
`else
                state_next = ST_FETCH;
`endif
              end
            end
          end
        end
      end
      ST_DONE: begin
        tx_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next    = ST_IDLE;
      ser_clear     = 1'b1;
      word_cnt_next = '0;
`ifdef SLAVE_OUT_PREFETCH_EN
      pf_issued_next   = 1'b0;
      pf_inflight_next = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cur_addr_reg <= '0;
      burst_reg    <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      burst_reg    <= burst_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

`ifdef SLAVE_OUT_PREFETCH_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pf_issued_reg   <= 1'b0;
      pf_inflight_reg <= 1'b0;
      pf_data_reg     <= '0;
    end else begin
      pf_issued_reg   <= pf_issued_next;
      pf_inflight_reg <= pf_inflight_next;
      pf_data_reg     <= pf_data_next;
    end
  end
`endif

  bit_serializer #(.DATA_LEN(DATA_LEN), .CNT_W(CNT_W)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .clear     (ser_clear),
    .load      (ser_load),
    .data      (ser_data),
    .shift_en  (ser_shift),
    .bit_out   (ser_bit),
    .last_bit  (ser_last)
`ifdef SLAVE_OUT_PREFETCH_EN
    ,
    .penult_bit(ser_penult)
`endif
  );

  assign mem_addr = cur_addr_reg;
  assign tx_data  = (state_reg == ST_SEND) && ser_bit;
  assign busy     = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_slave_out_port.sv
// Directed bench for slave_out_port: memory model, bit scoreboard and protocol checks.
module tb_slave_out_port;
  logic        clk = 1'b0;
  logic        reset, read_req, approval_grant, master_ready;
  logic [11:0] start_addr, burst_num;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_rd, slave_valid, tx_data, busy, tx_done;
  logic [11:0] mem_addr;

  logic [7:0]  mem [0:4095];
  bit          exp_q[$];
  int          valid_cyc_q[$];
  logic [11:0] rd_addr_q[$];
  int          errors = 0, checks = 0;
  int          cyc = 0, bits_seen = 0, done_count = 0, done_cyc = 0, last_valid_cyc = 0;
  int          rd_count = 0;
  logic [7:0]  rx_word = 8'h00;

`ifdef SLAVE_OUT_PREFETCH_EN
  localparam int SPAN3 = 23;
`else
  localparam int SPAN3 = 27;
`endif

  slave_out_port dut (
    .clk(clk), .reset(reset), .read_req(read_req), .start_addr(start_addr),
    .burst_num(burst_num), .approval_grant(approval_grant), .master_ready(master_ready),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_addr(mem_addr), .slave_valid(slave_valid),
    .tx_data(tx_data), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count++;
      rd_addr_q.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid bit must match the oldest expected bit
  always @(negedge clk) begin
    if (slave_valid === 1'b1) begin
      if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
      else check("bit", {31'd0, tx_data}, {31'd0, exp_q.pop_front()});
      bits_seen++;
      last_valid_cyc = cyc;
      valid_cyc_q.push_back(cyc);
      rx_word = {tx_data, rx_word[7:1]};
    end
    if (tx_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic start_burst(input logic [11:0] addr, input logic [11:0] n);
    logic [7:0]  w;
    logic [11:0] a;
    tick();
    read_req = 1'b1; start_addr = addr; burst_num = n;
    for (int i = 0; i <= int'(n); i++) begin
      a = addr + 12'(i);
      w = mem[a];
      for (int b = 0; b < 8; b++) exp_q.push_back(w[b]);
    end
    tick();
    read_req = 1'b0;
  endtask

  task automatic wait_bits(input string tag, input int target);
    int k = 0;
    while (bits_seen < target && k < 200) begin tick(); k++; end
    check(tag, bits_seen, target);
  endtask

  task automatic wait_done(input string tag, input int words);
    int d0 = done_count;
    int k = 0;
    while (done_count == d0 && k < 400) begin tick(); k++; end
    check({tag, "_done_seen"}, done_count, d0 + 1);
    check({tag, "_done_lat"}, done_cyc, last_valid_cyc + 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    sample();
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    $display("txn %s: words=%0d done at cycle %0d", tag, words, done_cyc);
  endtask

  initial begin
    int b0, r0, v0, d0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h010] = 8'hA5;
    mem[12'h020] = 8'h01; mem[12'h021] = 8'h80; mem[12'h022] = 8'hFF;
    mem[12'h030] = 8'h3C;
    mem[12'hFFF] = 8'h5A; mem[12'h000] = 8'hC3;
    reset = 1'b1; read_req = 1'b0; start_addr = '0; burst_num = '0;
    approval_grant = 1'b1; master_ready = 1'b1;
    repeat (3) tick();
    sample();
    check("rst_outputs", {15'd0, busy, mem_rd, slave_valid, tx_data, tx_done, mem_addr}, 32'd0);
    tick();
    reset = 1'b0;

    // single word 0xA5
    b0 = bits_seen; r0 = rd_count;
    start_burst(12'h010, 12'd0);
    wait_done("single", 1);
    check("single_bits", bits_seen - b0, 8);
    check("single_rx", {24'd0, rx_word}, 32'h0A5);
    check("single_rd", rd_count - r0, 1);

    // three-word burst, checks inter-word spacing
    b0 = bits_seen; r0 = rd_count; v0 = valid_cyc_q.size();
    start_burst(12'h020, 12'd2);
    wait_done("burst3", 3);
    check("burst3_bits", bits_seen - b0, 24);
    check("burst3_rd", rd_count - r0, 3);
    check("burst3_span", valid_cyc_q[v0 + 23] - valid_cyc_q[v0], SPAN3);

    // master stall at bit 4 of 0x3C
    b0 = bits_seen;
    start_burst(12'h030, 12'd0);
    wait_bits("stall_reach", b0 + 4);
    master_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("stall_valid", {31'd0, slave_valid}, 32'd0);
      check("stall_hold", {31'd0, tx_data}, 32'd1);
      tick();
    end
    master_ready = 1'b1;
    wait_done("stall", 1);
    check("stall_rx", {24'd0, rx_word}, 32'h03C);

    // grant drop at bit 5 of word 1 of a 4-word burst
    b0 = bits_seen; d0 = done_count;
    start_burst(12'h040, 12'd3);
    wait_bits("abort_reach", b0 + 13);
    approval_grant = 1'b0;
    sample();
    check("abort_valid", {31'd0, slave_valid}, 32'd0);
    tick();
    sample();
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    check("abort_no_done", done_count, d0);
    check("abort_bits", bits_seen - b0, 13);
    $display("txn abort: bits sent=%0d", bits_seen - b0);
    exp_q.delete();
    approval_grant = 1'b1;
    start_burst(12'h010, 12'd0);
    wait_done("after_abort", 1);
    check("after_abort_rx", {24'd0, rx_word}, 32'h0A5);

    // address wrap
    r0 = rd_count;
    start_burst(12'hFFF, 12'd1);
    wait_done("wrap", 2);
    check("wrap_rd", rd_count - r0, 2);
    check("wrap_addr0", {20'd0, rd_addr_q[r0]}, 32'hFFF);
    check("wrap_addr1", {20'd0, rd_addr_q[r0 + 1]}, 32'h000);
    check("wrap_rx", {24'd0, rx_word}, 32'h0C3);

    // reset mid-SEND, then an ungranted request
    b0 = bits_seen;
    start_burst(12'h020, 12'd2);
    wait_bits("rst_reach", b0 + 3);
    reset = 1'b1;
    tick();
    sample();
    check("midrst_outputs", {15'd0, busy, mem_rd, slave_valid, tx_data, tx_done, mem_addr}, 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    r0 = rd_count;
    approval_grant = 1'b0; read_req = 1'b1; start_addr = 12'h020; burst_num = 12'd0;
    tick();
    read_req = 1'b0;
    tick();
    approval_grant = 1'b1;
    repeat (4) tick();
    sample();
    check("nogrant_rd", rd_count - r0, 0);
    check("nogrant_busy", {31'd0, busy}, 32'd0);
    $display("txn ungranted request: reads=%0d", rd_count - r0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
